// File: rtl/bin2gray_counter.sv
// Up/down binary counter that registers BIN and its Gray code on the same edge.
// Optional `GRAY_STEP_CHECK_EN adds a sticky ERR flag for non-unit-distance Gray steps.
module bin2gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_BIN,
    output logic [WIDTH-1:0] BIN,
    output logic [WIDTH-1:0] GRAY,
    output logic             TC,
`ifdef GRAY_STEP_CHECK_EN
    output logic             WRAP,
    output logic             ERR
`else
    output logic             WRAP
`endif
);

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             tc;
    logic             step;

    always_comb begin
        step   = EN & ~LOAD;
        bin_d  = bin_q;
        if (LOAD) begin
            bin_d = LOAD_BIN;
        end else if (EN) begin
            bin_d = UP ? (bin_q + ONE) : (bin_q - ONE);
        end
        // Gray is encoded from the next binary value so both outputs move together.
        gray_d = bin_to_gray(bin_d);
        tc     = step & ((UP & (bin_q == ONES)) | (~UP & (bin_q == ZERO)));
        wrap_d = tc;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign BIN  = bin_q;
    assign GRAY = gray_q;
    assign TC   = tc;
    assign WRAP = wrap_q;

`ifdef GRAY_STEP_CHECK_EN
    // Checker register: previous GRAY plus a flag saying the last edge was a count step.
    logic [WIDTH-1:0] gray_prev_q;
    logic             chk_q;
    logic             err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (chk_q && (popcount(gray_prev_q ^ gray_q) != 1)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            gray_prev_q <= '0;
            chk_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            gray_prev_q <= gray_q;
            chk_q       <= step;
            err_q       <= err_d;
        end
    end

    assign ERR = err_q;
`endif

endmodule

// File: tb/tb_bin2gray_counter.sv
// Directed bench for bin2gray_counter (WIDTH=4) with hand-computed expectations.
module tb_bin2gray_counter;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST, EN, UP, LOAD;
    logic [W-1:0] LOAD_BIN;
    logic [W-1:0] BIN, GRAY;
    logic         TC, WRAP;
`ifdef GRAY_STEP_CHECK_EN
    logic         ERR;
`endif

    int n_pass  = 0;
    int n_total = 0;

    bin2gray_counter #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .UP       (UP),
        .LOAD     (LOAD),
        .LOAD_BIN (LOAD_BIN),
        .BIN      (BIN),
        .GRAY     (GRAY),
        .TC       (TC),
`ifdef GRAY_STEP_CHECK_EN
        .WRAP     (WRAP),
        .ERR      (ERR)
`else
        .WRAP     (WRAP)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                           input logic et, input logic ew);
        chk({tag, ".BIN"},  32'(BIN),  32'(eb));
        chk({tag, ".GRAY"}, 32'(GRAY), 32'(eg));
        chk({tag, ".TC"},   32'(TC),   32'(et));
        chk({tag, ".WRAP"}, 32'(WRAP), 32'(ew));
    endtask

    logic [3:0] gseq [18];

    initial begin
        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};

        // Reset for two cycles
        RST = 1'b1; EN = 1'b0; UP = 1'b1; LOAD = 1'b0; LOAD_BIN = 4'h0;
        tick(); tick();
        chk_all("reset", 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef GRAY_STEP_CHECK_EN
        chk("reset.ERR", 32'(ERR), 32'd0);
`endif

        // Count up 17 steps through the wrap
        RST = 1'b0; EN = 1'b1; UP = 1'b1;
        #1;
        for (int i = 0; i < 18; i++) begin
            chk_all($sformatf("up[%0d]", i), 4'(i % 16), gseq[i], (i == 15), (i == 16));
            if (i < 17) tick();
        end

        // Load with EN asserted: load wins
        LOAD = 1'b1; LOAD_BIN = 4'hA; EN = 1'b1;
        #1;
        chk("loadA.TC", 32'(TC), 32'd0);
        tick();
        chk_all("loadA", 4'hA, 4'hF, 1'b0, 1'b0);
        LOAD = 1'b0; UP = 1'b0;
        tick();
        chk_all("down_from_A", 4'h9, 4'hD, 1'b0, 1'b0);

        // Boundary value loaded while a wrapping step is pending: no TC, no WRAP
        LOAD = 1'b1; LOAD_BIN = 4'hF; EN = 1'b0;
        tick();
        LOAD_BIN = 4'h0; EN = 1'b1; UP = 1'b1;
        #1;
        chk("load_over_tc.TC", 32'(TC), 32'd0);
        tick();
        chk_all("load_zero", 4'h0, 4'h0, 1'b0, 1'b0);

        // Load equal to current value leaves registers unchanged
        LOAD_BIN = 4'h0; EN = 1'b0;
        tick();
        chk_all("load_same", 4'h0, 4'h0, 1'b0, 1'b0);
        LOAD = 1'b0;

        // Down from reset wraps to all-ones
        RST = 1'b1;
        tick();
        RST = 1'b0; EN = 1'b1; UP = 1'b0;
        #1;
        chk("down_wrap.TC", 32'(TC), 32'd1);
        tick();
        chk_all("down_wrap", 4'hF, 4'h8, 1'b0, 1'b1);
        tick();
        chk_all("down_after", 4'hE, 4'h9, 1'b0, 1'b0);

        // Count to 0101 then hold for five cycles
        RST = 1'b1; EN = 1'b0;
        tick();
        RST = 1'b0; EN = 1'b1; UP = 1'b1;
        repeat (5) tick();
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("hold[%0d]", i), 4'h5, 4'h7, 1'b0, 1'b0);
        end

        // Reset beats load and enable
        EN = 1'b1;
        tick();
        chk_all("pre_rst", 4'h6, 4'h5, 1'b0, 1'b0);
        RST = 1'b1; LOAD = 1'b1; LOAD_BIN = 4'hF;
        tick();
        chk_all("rst_over_load", 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef GRAY_STEP_CHECK_EN
        chk("rst_over_load.ERR", 32'(ERR), 32'd0);
`endif
        RST = 1'b0; LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
        tick();
        chk_all("resume", 4'h1, 4'h1, 1'b0, 1'b0);

`ifdef GRAY_STEP_CHECK_EN
        // Full up/down sweep and three loads never flag an error
        RST = 1'b1; EN = 1'b0;
        tick();
        RST = 1'b0; EN = 1'b1; UP = 1'b1;
        repeat (16) tick();
        UP = 1'b0;
        repeat (16) tick();
        EN = 1'b0; LOAD = 1'b1;
        LOAD_BIN = 4'h7; tick();
        LOAD_BIN = 4'h2; tick();
        LOAD_BIN = 4'h5; tick();
        LOAD = 1'b0;
        tick();
        chk("sweep.ERR", 32'(ERR), 32'd0);
        chk("sweep.BIN", 32'(BIN), 32'h5);

        // Corrupt GRAY before a step from 0101
        force dut.gray_q = 4'b0011;
        #1;
        release dut.gray_q;
        EN = 1'b1; UP = 1'b1;
        tick();
        EN = 1'b0;
        tick();
        chk("forced.ERR", 32'(ERR), 32'd1);
        repeat (3) tick();
        chk("sticky.ERR", 32'(ERR), 32'd1);
        RST = 1'b1;
        tick();
        chk("cleared.ERR", 32'(ERR), 32'd0);
        RST = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bin2gray_counter.md
Name: bin2gray_counter

Overview:
Up/down binary counter that publishes its state as registered Gray code. It is the encode-side companion of the Gray-to-binary converter. It produces the Gray-coded sequence that the converter consumes, for example as a write pointer crossing a clock domain or as a stimulus source for the decoder. BIN and GRAY update on the same edge, so GRAY always equals the Gray encoding of BIN.

Parameters:
WIDTH, 4, counter and code width in bits (2 to 32).

Ports:
CLK  input  1  single clock; all state changes on its rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  count enable; one step per cycle while high.
UP  input  1  direction; 1 = increment, 0 = decrement. Sampled only when a step occurs.
LOAD  input  1  synchronous load of LOAD_BIN; takes priority over EN.
LOAD_BIN  input  WIDTH  binary value to load.
BIN  output  WIDTH  registered binary count.
GRAY  output  WIDTH  registered Gray code of BIN.
TC  output  1  combinational terminal-count flag.
WRAP  output  1  registered one-cycle pulse marking a step that wrapped.
ERR  output  1  sticky step-check error; present only with the optional feature.

Behaviour:
- Reset state: BIN = 0, GRAY = 0, WRAP = 0, ERR = 0. TC follows its equation.
- Priority per edge: RST, then LOAD, then EN, then hold.
- Next binary value N:
  - LOAD: N = LOAD_BIN.
  - EN with UP = 1: N = BIN + 1, modulo 2^WIDTH.
  - EN with UP = 0: N = BIN - 1, modulo 2^WIDTH.
  - Otherwise: N = BIN.
- Register update: BIN <= N and GRAY <= N ^ (N >> 1), both on the same edge. GRAY is never derived from the old BIN, and there is no added latency between the two outputs.
- Latency: one cycle from the EN/LOAD sample to the new BIN/GRAY.
- Wrap rules:
  - Up from all-ones gives 0; Gray goes 100..0 to 000..0.
  - Down from 0 gives all-ones; Gray goes 000..0 to 100..0.
- WRAP <= 1 for exactly one cycle after an EN step that wrapped. WRAP <= 0 after a LOAD, a hold, or RST, even if the loaded value is a boundary value.
- TC = EN & ~LOAD & ((UP & BIN == all-ones) | (~UP & BIN == 0)). It is high in the cycle before a wrapping step.
- LOAD and EN asserted together: the load wins, no step is taken, and WRAP = 0.
- LOAD_BIN equal to the current BIN: registers unchanged, no error.
- RST mid-count, including with LOAD or EN asserted: the next edge gives all outputs their reset values. The count resumes from 0 on the first edge after RST deasserts.
- No internal state beyond the BIN, GRAY, WRAP and ERR registers, plus the checker register when the optional feature is compiled in.

Optional Feature:
GRAY_STEP_CHECK_EN
- Defined:
  - A shadow register holds the previous GRAY value.
  - On every EN step (not LOAD, not hold), if the popcount of GRAY_prev ^ GRAY_new is not exactly 1, ERR is set and stays set until RST.
  - Loads and holds never set ERR.
  - The ERR port exists.
- Undefined: the ERR port and the shadow register are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, RST for 2 cycles, then EN=1, UP=1 for 17 cycles -> GRAY sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000,0001. TC=1 while BIN=1111; WRAP pulses exactly once, in the cycle where BIN=0000.
- LOAD=1, LOAD_BIN=1010, EN=1 -> next cycle BIN=1010, GRAY=1111, WRAP=0. Then EN=1, UP=0 -> BIN=1001, GRAY=1101.
- From reset, EN=1, UP=0 -> TC=1 in the first cycle; next cycle BIN=1111, GRAY=1000, WRAP=1. The following step gives BIN=1110, GRAY=1001, WRAP=0.
- Count to BIN=0101, then EN=0 for 5 cycles -> BIN=0101 and GRAY=0111 stable, TC=0, WRAP=0.
- BIN=0110 with RST=1, LOAD=1, LOAD_BIN=1111 in the same cycle -> next cycle BIN=0000, GRAY=0000, WRAP=0 (and ERR=0 when the feature is compiled in).
- With GRAY_STEP_CHECK_EN defined: a full 32-step up/down sweep plus 3 loads -> ERR stays 0. Force the GRAY register via the bench to 0011 before a step from BIN=0101 -> ERR=1, and it stays 1 until RST.
